// File: rtl/pc_unit_stack_pkg.sv
// Shared definitions for the stack-based program counter: command select codes and clog2.
`default_nettype none

package pc_unit_stack_pkg;

  // Winning command after priority resolution; reset and stall are applied outside this code.
  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INC  = 3'd1,
    CMD_BR   = 3'd2,
    CMD_LD   = 3'd3,
    CMD_CALL = 3'd4,
    CMD_RET  = 3'd5
  } cmd_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        result = result + 1;
        v      = v >> 1;
      end
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_unit_stack_ret_stack.sv
// Parametrised LIFO of return addresses; push when full and pop when empty are no-ops.
`default_nettype none

module ret_stack
  import pc_unit_stack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic [clog2(DEPTH):0] depth,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (depth == (AW+1)'(DEPTH));
  assign empty   = (depth == '0);
  assign wr_idx  = depth[AW-1:0];
  assign top_idx = depth[AW-1:0] - AW'(1);

  // Pop takes precedence so a simultaneous push/pop never grows the stack.
  assign do_pop  = pop && !empty;
  assign do_push = push && !full && !do_pop;

  assign dout = mem[top_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      depth <= '0;
    end else if (do_pop) begin
      depth <= depth - (AW+1)'(1);
    end else if (do_push) begin
      depth <= depth + (AW+1)'(1);
    end
  end

  // Entry storage carries no reset; contents are meaningless once depth is cleared.
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit_stack.sv
// Program counter with reset vector, relative branch, return-address stack and stall.
`default_nettype none

module pc_unit_stack
  import pc_unit_stack_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              OFF_W     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  pc_inc,
  input  logic                  pc_ld,
  input  logic                  pc_br,
  input  logic                  pc_call,
  input  logic                  pc_ret,
  input  logic                  err_clr,
  input  logic [PC_W-1:0]       alu_out,
  input  logic [OFF_W-1:0]      br_off,
  output logic [PC_W-1:0]       PC,
  output logic [clog2(DEPTH):0] stk_depth,
  output logic                  stk_full,
  output logic                  stk_empty,
  output logic                  stk_ovf,
  output logic                  stk_unf
);

  cmd_e            cmd;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] stk_top;
  logic            push;
  logic            pop;
  logic            ovf_set;
  logic            unf_set;

  always_comb begin
    cmd = CMD_HOLD;
    if (stall)        cmd = CMD_HOLD;
    else if (pc_ret)  cmd = CMD_RET;
    else if (pc_call) cmd = CMD_CALL;
    else if (pc_ld)   cmd = CMD_LD;
    else if (pc_br)   cmd = CMD_BR;
    else if (pc_inc)  cmd = CMD_INC;
  end

  assign pc_plus1 = PC + PC_W'(1);
  assign off_ext  = PC_W'($signed(br_off));

  assign push = (cmd == CMD_CALL);
  assign pop  = (cmd == CMD_RET);

  ret_stack #(
    .DEPTH (DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .dout  (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // A return on an empty stack falls through to the next sequential instruction.
  always_comb begin
    pc_next = PC;
    case (cmd)
      CMD_INC:  pc_next = pc_plus1;
      CMD_BR:   pc_next = PC + off_ext;
      CMD_LD:   pc_next = alu_out;
      CMD_CALL: pc_next = alu_out;
      CMD_RET:  pc_next = stk_empty ? pc_plus1 : stk_top;
      default:  pc_next = PC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      PC <= RESET_VEC;
    end else begin
      PC <= pc_next;
    end
  end

  assign ovf_set = (cmd == CMD_CALL) && stk_full;
  assign unf_set = (cmd == CMD_RET) && stk_empty;

  // Clearing is honoured during stall; a fresh error in the same cycle wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      stk_ovf <= (stk_ovf && !err_clr) || ovf_set;
      stk_unf <= (stk_unf && !err_clr) || unf_set;
    end
  end

endmodule

`default_nettype wire
